// File: rtl/lab3_cache_mem_arbiter.sv
// lab3_cache_mem_arbiter: round-robin arbiter sharing one memory port between icache (port 0) and dcache (port 1)
//
// Holds the grant for a p_beats-long burst and routes responses back through an in-order owner FIFO.
// Optional macro LAB3_CACHE_MEM_ARB_FIXED_PRIO_EN: port 1 always wins a tie (no round-robin pointer).
//
// Ports:
//   clk, reset (async, active-low)
//   req0_*/req1_*     : val/rdy/msg/burst request streams from the two caches
//   mem_req_*         : muxed request to memory
//   mem_resp_*        : response from memory
//   resp0_*/resp1_*   : responses routed back to the requesting port
//   busy              : burst locked or responses outstanding
module lab3_cache_mem_arbiter #(
    parameter int p_msg_nbits  = 77,
    parameter int p_resp_nbits = 47,
    parameter int p_beats      = 4,
    parameter int p_depth      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_msg_nbits-1:0]  req0_msg,
    input  logic                    req0_burst,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_msg_nbits-1:0]  req1_msg,
    input  logic                    req1_burst,
    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    output logic [p_msg_nbits-1:0]  mem_req_msg,
    input  logic                    mem_resp_val,
    output logic                    mem_resp_rdy,
    input  logic [p_resp_nbits-1:0] mem_resp_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_resp_nbits-1:0] resp0_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,
    output logic                    busy
);
    localparam int BW = p_beats > 1 ? $clog2(p_beats) : 1;
    localparam int AW = $clog2(p_depth);
    typedef enum logic {ARB, LOCK} state_t;
    state_t state, state_n;
    logic owner, owner_n;
    logic [BW-1:0] beat_cnt, beat_cnt_n;
    logic [p_depth-1:0] fifo;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic full, empty, head, gnt, burst, push, pop, last, tie;
    assign full  = count == (AW+1)'(p_depth);
    assign empty = count == '0;
    assign head  = fifo[rd_ptr];
    assign last  = beat_cnt == BW'(p_beats - 1);
`ifndef LAB3_CACHE_MEM_ARB_FIXED_PRIO_EN
    logic prio;
    assign tie = prio;
    // Single beats hand priority to the other port; a burst hands it over only on its last beat.
    always_ff @(posedge clk or negedge reset)
        if (!reset) prio <= 1'b0;
        else if (push) prio <= (state == LOCK) ? (last ? !owner : prio) : (burst && p_beats > 1) ? prio : !gnt;
`else
    assign tie = 1'b1;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB;
            owner    <= 1'b0;
            beat_cnt <= '0;
            fifo     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            beat_cnt <= beat_cnt_n;
            if (push) begin
                fifo[wr_ptr] <= gnt;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        beat_cnt_n = beat_cnt;
        if (push && state == LOCK) begin
            state_n    = last ? ARB : LOCK;
            beat_cnt_n = last ? '0 : beat_cnt + 1'b1;
        end else if (push && burst && p_beats > 1) begin
            state_n    = LOCK;
            owner_n    = gnt;
            beat_cnt_n = BW'(1);
        end
    end
    // Full blocks new beats regardless of a same-cycle pop, keeping response and request paths independent.
    always_comb begin
        gnt          = (state == LOCK) ? owner : (req0_val & req1_val) ? tie : req1_val;
        mem_req_val  = reset & !full & (gnt ? req1_val : req0_val);
        mem_req_msg  = gnt ? req1_msg : req0_msg;
        burst        = gnt ? req1_burst : req0_burst;
        req0_rdy     = mem_req_val & mem_req_rdy & !gnt;
        req1_rdy     = mem_req_val & mem_req_rdy & gnt;
        push         = mem_req_val & mem_req_rdy;
        resp0_val    = mem_resp_val & !empty & !head;
        resp1_val    = mem_resp_val & !empty & head;
        mem_resp_rdy = !empty & (head ? resp1_rdy : resp0_rdy);
        pop          = mem_resp_val & mem_resp_rdy;
        resp0_msg    = mem_resp_msg;
        resp1_msg    = mem_resp_msg;
        busy         = (state == LOCK) | !empty;
    end
endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// tb_lab3_cache_mem_arbiter: self-checking bench for lab3_cache_mem_arbiter
module tb_lab3_cache_mem_arbiter;
    localparam int MSG = 77, RESP = 47, BEATS = 4, DEPTH = 8;
`ifdef LAB3_CACHE_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0;
    logic req0_val = 1'b0, req0_rdy, req0_burst = 1'b0;
    logic req1_val = 1'b0, req1_rdy, req1_burst = 1'b0;
    logic [MSG-1:0] req0_msg = '0, req1_msg = '0, mem_req_msg;
    logic mem_req_val, mem_req_rdy = 1'b0;
    logic mem_resp_val = 1'b0, mem_resp_rdy;
    logic [RESP-1:0] mem_resp_msg = '0, resp0_msg, resp1_msg;
    logic resp0_val, resp0_rdy = 1'b0, resp1_val, resp1_rdy = 1'b0, busy;

    always #5 clk = ~clk;

    lab3_cache_mem_arbiter #(.p_msg_nbits(MSG), .p_resp_nbits(RESP), .p_beats(BEATS), .p_depth(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg), .req0_burst(req0_burst),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg), .req1_burst(req1_burst),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .busy(busy)
    );

    int checks = 0, passed = 0, cyc = 0;
    int oq[$];
    int glog[$], gcyc[$];
    bit m_lock = 0;
    int m_owner = 0, m_left = 0, m_prio = 0;
    bit e_push = 0, e_pop = 0, e_burst = 0;
    int e_g = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: owners queue, lock with beats remaining, round-robin pointer.
    always @(negedge clk) begin
        bit full, empty, ev, erdy;
        int g, hp;
        if (!reset) begin
            oq.delete();
            m_lock = 0; m_owner = 0; m_left = 0; m_prio = 0;
        end
        full  = oq.size() == DEPTH;
        empty = oq.size() == 0;
        hp    = empty ? 0 : oq[0];
        g     = m_lock ? m_owner : (req0_val && req1_val) ? (FIXED ? 1 : m_prio) : (req1_val ? 1 : 0);
        ev    = reset && !full && (g == 1 ? req1_val : req0_val);
        erdy  = !empty && (hp == 1 ? resp1_rdy : resp0_rdy);
        check("mem_req_val", mem_req_val, ev);
        if (ev) check("mem_req_msg", mem_req_msg, g == 1 ? req1_msg : req0_msg);
        if (req0_val) check("req0_rdy", req0_rdy, ev && mem_req_rdy && g == 0);
        if (req1_val) check("req1_rdy", req1_rdy, ev && mem_req_rdy && g == 1);
        check("mem_resp_rdy", mem_resp_rdy, erdy);
        check("resp0_val", resp0_val, mem_resp_val && !empty && hp == 0);
        check("resp1_val", resp1_val, mem_resp_val && !empty && hp == 1);
        if (resp0_val) check("resp0_msg", resp0_msg, mem_resp_msg);
        if (resp1_val) check("resp1_msg", resp1_msg, mem_resp_msg);
        check("busy", busy, m_lock || !empty);
        e_push  = ev && mem_req_rdy;
        e_pop   = mem_resp_val && erdy;
        e_g     = g;
        e_burst = g == 1 ? req1_burst : req0_burst;
    end

    always @(posedge clk) if (reset) begin
        cyc++;
        if (e_pop) void'(oq.pop_front());
        if (e_push) begin
            oq.push_back(e_g);
            glog.push_back(e_g);
            gcyc.push_back(cyc);
            if (m_lock) begin
                m_left--;
                if (m_left == 0) begin m_lock = 0; m_prio = 1 - m_owner; end
            end else if (e_burst) begin
                m_lock = 1; m_owner = e_g; m_left = BEATS - 1;
            end else m_prio = 1 - e_g;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req0_msg     = MSG'({$urandom(), $urandom(), $urandom()});
        req1_msg     = MSG'({$urandom(), $urandom(), $urandom()});
        mem_resp_msg = RESP'({$urandom(), $urandom()});
    endtask

    task automatic drain(input string name);
        mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        for (int i = 0; i < 20 && oq.size() != 0; i++) step();
        mem_resp_val = 0;
        #2 check({name, "_drained_busy"}, busy, 0);
        step();
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, "_count"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) check(name, i < glog.size() ? glog[i] : -1, exp[i]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        req0_val = 1; req1_val = 1; mem_req_rdy = 1;
        #2;
        check("rst_mem_req_val", mem_req_val, 0);
        check("rst_req0_rdy", req0_rdy, 0);
        check("rst_req1_rdy", req1_rdy, 0);
        check("rst_busy", busy, 0);
        req0_val = 0; req1_val = 0;
        reset = 1;

        // single port, three single beats
        glog.delete(); gcyc.delete();
        req0_val = 1;
        repeat (3) step();
        req0_val = 0;
        check_log("s1_grant", '{0, 0, 0});
        check("s1_consecutive", gcyc.size() == 3 ? gcyc[2] - gcyc[0] : -1, 2);
        drain("s1");

        // tie with fresh pointer
        reset = 0; step(); reset = 1;
        glog.delete(); gcyc.delete();
        req0_val = 1; req1_val = 1;
        repeat (4) step();
        req0_val = 0; req1_val = 0;
        if (FIXED) check_log("s2_grant", '{1, 1, 1, 1});
        else check_log("s2_grant", '{0, 1, 0, 1});
        drain("s2");

        // burst lock by port 1 while port 0 stays valid
        glog.delete(); gcyc.delete();
        req0_val = 1;
        step();
        req1_val = 1; req1_burst = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                #2;
                check("s3_lock_req0_rdy", req0_rdy, 0);
                check("s3_lock_req1_rdy", req1_rdy, 1);
                check("s3_lock_busy", busy, 1);
            end
            step();
        end
        req1_val = 0; req1_burst = 0;
        step();
        req0_val = 0;
        check_log("s3_grant", '{0, 1, 1, 1, 1, 0});
        check("s3_reopen_cycle", gcyc.size() == 6 ? gcyc[5] - gcyc[1] : -1, 4);
        drain("s3");

        // owner FIFO full
        glog.delete(); gcyc.delete();
        req0_val = 1;
        repeat (8) step();
        #2;
        check("s4_full_req0_rdy", req0_rdy, 0);
        check("s4_full_mem_req_val", mem_req_val, 0);
        step();
        mem_resp_val = 1; resp0_rdy = 1;
        #2;
        check("s4_pop_mem_resp_rdy", mem_resp_rdy, 1);
        check("s4_pop_req0_rdy", req0_rdy, 0);
        step();
        mem_resp_val = 0;
        #2 check("s4_after_pop_req0_rdy", req0_rdy, 1);
        step();
        req0_val = 0;
        check("s4_beats", glog.size(), 9);
        drain("s4");

        // response backpressure on head entry
        req0_val = 1;
        step();
        req0_val = 0;
        mem_resp_val = 1; resp0_rdy = 0; resp1_rdy = 1;
        #2;
        check("s5_stall_mem_resp_rdy", mem_resp_rdy, 0);
        check("s5_stall_resp0_val", resp0_val, 1);
        step();
        resp0_rdy = 1;
        #2 check("s5_release_mem_resp_rdy", mem_resp_rdy, 1);
        step();
        mem_resp_val = 0;
        #2 check("s5_done_busy", busy, 0);
        step();

        // reset in the middle of a burst
        req1_val = 1; req1_burst = 1;
        step();
        step();
        reset = 0;
        #1;
        check("s6_rst_mem_req_val", mem_req_val, 0);
        check("s6_rst_req1_rdy", req1_rdy, 0);
        check("s6_rst_busy", busy, 0);
        step();
        reset = 1; req1_burst = 0;
        glog.delete(); gcyc.delete();
        req0_val = 1; req1_val = 1;
        mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        #2 check("s6_stray_mem_resp_rdy", mem_resp_rdy, 0);
        step();
        step();
        req0_val = 0; req1_val = 0;
        if (FIXED) check_log("s6_grant", '{1, 1});
        else check_log("s6_grant", '{0, 1});
        drain("s6");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
